// File: rtl/pwm_pkg.sv
// Shared types and constants for the complementary PWM driver with dead time.
package pwm_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    DEAD     = 2'd1,
    DRIVE_HI = 2'd2,
    DRIVE_LO = 2'd3
  } pwm_state_t;

  localparam logic [7:0] PWM_CNT_MAX = 8'd254;

  function automatic logic [7:0] cnt_next(input logic [7:0] cnt);
    return (cnt == PWM_CNT_MAX) ? 8'd0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: free-running 0..PRESCALE-1 counter with a one-clk tick on the
// last count. Clear holds the counter at zero and suppresses the tick.
module pwm_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    if (clear) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST) & ~clear;

endmodule

// File: rtl/pwm_dead_time_driver.sv
// Complementary half-bridge PWM with double-buffered duty and programmable dead
// time; both gates are driven from flops that decode the next FSM state.
module pwm_dead_time_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int DEAD_TIME = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       pwm_hi,
  output logic       pwm_lo,
  output logic       period_start,
  output logic [7:0] duty_active
);

  localparam logic [3:0] DEAD_LAST = 4'(DEAD_TIME - 1);

  pwm_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] duty_active_q, duty_active_d;
  logic [3:0] dead_q, dead_d;
  logic       pwm_hi_q, pwm_hi_d;
  logic       pwm_lo_q, pwm_lo_d;
  logic       period_start_q, period_start_d;

  logic tick_s;
  logic presc_clear_s;
  logic raw_hi_s;
  logic wrap_s;
  logic load_s;

  // Holding the prescaler in OFF aligns its phase with the period load on enable.
  assign presc_clear_s = ~enable | (state_q == OFF);

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(presc_clear_s),
    .tick (tick_s)
  );

  assign raw_hi_s = (cnt_q < duty_active_q);
  assign wrap_s   = tick_s & (cnt_q == PWM_CNT_MAX);
  assign load_s   = enable & ((state_q == OFF) | wrap_s);

  always_comb begin
    shadow_d       = duty_valid ? duty_in : shadow_q;
    period_start_d = load_s;
    if (load_s) begin
      duty_active_d = shadow_d;
    end else begin
      duty_active_d = duty_active_q;
    end
    if (!enable) begin
      cnt_d = 8'd0;
    end else if (tick_s) begin
      cnt_d = cnt_next(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = 4'd0;
    if (!enable) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:      state_d = DEAD;
        DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = raw_hi_s ? DRIVE_HI : DRIVE_LO;
          end else begin
            dead_d = dead_q + 4'd1;
          end
        end
        DRIVE_HI: begin
          if (!raw_hi_s) begin
            state_d = DEAD;
          end else begin
            state_d = DRIVE_HI;
          end
        end
        DRIVE_LO: begin
          if (raw_hi_s) begin
            state_d = DEAD;
          end else begin
            state_d = DRIVE_LO;
          end
        end
        default:  state_d = OFF;
      endcase
    end
    pwm_hi_d = (state_d == DRIVE_HI);
    pwm_lo_d = (state_d == DRIVE_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= OFF;
      cnt_q          <= 8'd0;
      shadow_q       <= 8'd0;
      duty_active_q  <= 8'd0;
      dead_q         <= 4'd0;
      pwm_hi_q       <= 1'b0;
      pwm_lo_q       <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      duty_active_q  <= duty_active_d;
      dead_q         <= dead_d;
      pwm_hi_q       <= pwm_hi_d;
      pwm_lo_q       <= pwm_lo_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_hi       = pwm_hi_q;
  assign pwm_lo       = pwm_lo_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_dead_time_driver.sv
// Directed bench for pwm_dead_time_driver: duty scoreboard checked at period starts,
// waveform patterns per counter position, and an always-on overlap/dead-gap monitor.
module tb_pwm_dead_time_driver;

  logic       clk = 1'b0;
  logic       rst_n, enable, duty_valid;
  logic [7:0] duty_in;
  logic       pwm_hi, pwm_lo, period_start;
  logic [7:0] duty_active;

  logic       en2, dv2;
  logic [7:0] din2;
  logic       hi2, lo2, ps2;
  logic [7:0] da2;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_active = 8'd0;
  bit         pending = 1'b0;
  bit         mon_en = 1'b0;
  int         last_side = 0;
  int         low_run = 0;

  always #5 clk = ~clk;

  pwm_dead_time_driver #(.PRESCALE(1), .DEAD_TIME(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in),
    .duty_valid(duty_valid), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
    .period_start(period_start), .duty_active(duty_active)
  );

  pwm_dead_time_driver #(.PRESCALE(3), .DEAD_TIME(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .duty_in(din2),
    .duty_valid(dv2), .pwm_hi(hi2), .pwm_lo(lo2),
    .period_start(ps2), .duty_active(da2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Last pulse within a period replaces any earlier pending value.
  task automatic send_sb(input logic [7:0] v);
    if (pending) void'(sb.pop_back());
    sb.push_back(v);
    pending = 1'b1;
  endtask

  task automatic check_start();
    chk("period_start", period_start, 1'b1);
    if (sb.size() > 0) exp_active = sb.pop_front();
    pending = 1'b0;
    chk("duty_active", duty_active, exp_active);
  endtask

  // Steady period of duty d following a period that ended on the low side.
  task automatic run_period(input int d, input int ka, input logic [7:0] va,
                            input int kb, input logic [7:0] vb);
    logic eh, el;
    for (int k = 0; k < 255; k++) begin
      eh = (k >= 3) && (k <= d);
      el = (k == 0) || (k >= d + 3);
      chk("pattern_hi", pwm_hi, eh);
      chk("pattern_lo", pwm_lo, el);
      chk("ps_in_period", period_start, (k == 0));
      duty_valid = 1'b0;
      if (k == ka) begin
        duty_valid = 1'b1; duty_in = va; send_sb(va);
      end else if (k == kb) begin
        duty_valid = 1'b1; duty_in = vb; send_sb(vb);
      end
      step();
    end
    duty_valid = 1'b0;
    check_start();
  endtask

  task automatic wait_start(input int n0, output int n);
    n = n0;
    for (int i = 0; i < 600; i++) begin
      step();
      n++;
      if (period_start) break;
    end
  endtask

  // Monitor: no overlap ever, and every hi<->lo switch-over has >= 2 low clks.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      assert (!(pwm_hi === 1'b1 && pwm_lo === 1'b1)) else begin
        fails++;
        $error("FAIL overlap: observed hi=%0b lo=%0b expected not both 1", pwm_hi, pwm_lo);
      end
      if (pwm_hi === 1'b1) begin
        if (last_side == 2) chk("dead_gap_lo_hi", (low_run >= 2), 1'b1);
        last_side = 1;
        low_run = 0;
      end else if (pwm_lo === 1'b1) begin
        if (last_side == 1) chk("dead_gap_hi_lo", (low_run >= 2), 1'b1);
        last_side = 2;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  initial begin
    int n, hc, lc;
    rst_n = 1'b0; enable = 1'b1; duty_valid = 1'b1; duty_in = 8'd200;
    en2 = 1'b0; dv2 = 1'b0; din2 = 8'd0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hi", pwm_hi, 1'b0);
      chk("rst_lo", pwm_lo, 1'b0);
      chk("rst_ps", period_start, 1'b0);
      chk("rst_duty", duty_active, 8'd0);
    end
    mon_en = 1'b1;

    // Load 128 while disabled, then enable.
    rst_n = 1'b1; enable = 1'b0; duty_valid = 1'b1; duty_in = 8'd128;
    send_sb(8'd128);
    step();
    chk("pre_en_hi", pwm_hi, 1'b0);
    chk("pre_en_duty", duty_active, 8'd0);
    duty_valid = 1'b0; enable = 1'b1;
    step();
    check_start();
    chk("en_dead0", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("en_dead1", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("en_first_hi", {pwm_hi, pwm_lo}, 2'b10);
    wait_start(2, n);
    chk("period_len", n, 255);
    check_start();

    run_period(128, 100, 8'd50, -1, 8'd0);
    run_period(50, 10, 8'd77, 200, 8'd90);
    run_period(90, 254, 8'd255, -1, 8'd0);
    run_period(255, -1, 8'd0, -1, 8'd0);

    // Full duty: high side held through an entire period.
    for (int k = 0; k < 255; k++) begin
      chk("full_hi", {pwm_hi, pwm_lo}, 2'b10);
      step();
    end
    check_start();
    for (int k = 0; k < 50; k++) begin
      chk("full_hi2", {pwm_hi, pwm_lo}, 2'b10);
      step();
    end
    enable = 1'b0;
    step();
    chk("dis_outs", {pwm_hi, pwm_lo}, 2'b00);
    chk("dis_ps", period_start, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_hold", {pwm_hi, pwm_lo, period_start}, 3'b000);
    end
    enable = 1'b1;
    step();
    check_start();
    chk("reen_dead0", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("reen_dead1", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("reen_hi", {pwm_hi, pwm_lo}, 2'b10);
    wait_start(2, n);
    chk("reen_period_len", n, 255);
    check_start();

    // Zero duty captured while disabled.
    enable = 1'b0; duty_valid = 1'b1; duty_in = 8'd0;
    send_sb(8'd0);
    step();
    chk("zero_dis", {pwm_hi, pwm_lo}, 2'b00);
    duty_valid = 1'b0;
    step();
    enable = 1'b1;
    step();
    check_start();
    chk("zero_dead0", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("zero_dead1", {pwm_hi, pwm_lo}, 2'b00);
    step();
    chk("zero_lo", {pwm_hi, pwm_lo}, 2'b01);
    for (int i = 0; i < 300; i++) begin
      step();
      chk("zero_hold", {pwm_hi, pwm_lo}, 2'b01);
    end

    // Second instance: PRESCALE=3, DEAD_TIME=1, duty 100.
    dv2 = 1'b1; din2 = 8'd100;
    step();
    dv2 = 1'b0; en2 = 1'b1;
    step();
    chk("p3_start", ps2, 1'b1);
    chk("p3_duty", da2, 8'd100);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      n++;
      if (ps2) break;
    end
    chk("p3_period_len", n, 765);
    hc = 0; lc = 0;
    for (int k = 0; k < 765; k++) begin
      hc += int'(hi2);
      lc += int'(lo2);
      step();
    end
    chk("p3_start2", ps2, 1'b1);
    chk("p3_hi_clks", hc, 299);
    chk("p3_lo_clks", lc, 464);

    // Random enable/reset/duty traffic under the overlap and gap monitor.
    for (int i = 0; i < 5000; i++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      enable     = ($urandom_range(0, 199) != 0);
      duty_valid = ($urandom_range(0, 7) == 0);
      duty_in    = 8'($urandom_range(0, 255));
      step();
    end
    rst_n = 1'b1; duty_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
